audio_framer: RTL and testbench

- Consumes the mono line-in sample stream from the PMOD I2S2 codec interface: 24-bit signed samples, one single-cycle valid pulse per 48 kHz frame.
- Stores samples in a ring buffer.
- Every HOP_LEN new samples, streams out the most recent FRAME_LEN samples, oldest first, over a valid/ready interface.
- Feeds the analysis (window/FFT) stage of the vocoder.

---
 rtl/audio_framer.sv | 200 ++++++++++++++++++++
 tb/tb_audio_framer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_framer.sv
// audio_framer: ring-buffered framer that emits the latest FRAME_LEN samples every HOP_LEN writes.
// Define FRAMER_DC_BLOCK_EN to insert a saturating DC-blocking high-pass ahead of the buffer.
module audio_framer #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FRAME_LEN    = 512,
  parameter int HOP_LEN      = 256,
  parameter int DC_SHIFT     = 8
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           sample_valid_in,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  output logic                           frame_valid_out,
  input  logic                           frame_ready_in,
  output logic signed [SAMPLE_WIDTH-1:0] frame_data_out,
  output logic [$clog2(FRAME_LEN)-1:0]   frame_index_out,
  output logic                           frame_last_out,
  output logic                           overrun_out
);
  localparam int DEPTH = 2 * FRAME_LEN;
  localparam int PW    = $clog2(DEPTH);
  localparam int IW    = $clog2(FRAME_LEN);
  localparam int FW    = $clog2(FRAME_LEN + 1);
  localparam int HW    = $clog2(HOP_LEN + 1);

  typedef enum logic {IDLE, STREAM} state_t;

  logic signed [SAMPLE_WIDTH-1:0] mem [DEPTH];

  logic                           wr_vld_p0;
  logic signed [SAMPLE_WIDTH-1:0] wr_data_p0;

  // ---- stage p0: sample conditioning into the buffer write port ----
`ifdef FRAMER_DC_BLOCK_EN
  localparam int AW = SAMPLE_WIDTH + 2;

  logic signed [SAMPLE_WIDTH-1:0] x_prev;
  logic signed [SAMPLE_WIDTH-1:0] y_prev;
  logic signed [AW-1:0]           dc_acc;

  function automatic logic signed [SAMPLE_WIDTH-1:0] sat_sample(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] max_v;
    logic signed [AW-1:0] min_v;
    max_v = {3'b000, {(SAMPLE_WIDTH-1){1'b1}}};
    min_v = {3'b111, {(SAMPLE_WIDTH-1){1'b0}}};
    if (v > max_v)      return max_v[SAMPLE_WIDTH-1:0];
    else if (v < min_v) return min_v[SAMPLE_WIDTH-1:0];
    else                return v[SAMPLE_WIDTH-1:0];
  endfunction

  always_comb begin
    dc_acc = AW'(sample_in) - AW'(x_prev) + AW'(y_prev) - AW'(y_prev >>> DC_SHIFT);
  end

  // y_prev doubles as the write data: it is the most recent filtered output.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_vld_p0 <= 1'b0;
      x_prev    <= '0;
      y_prev    <= '0;
    end else begin
      wr_vld_p0 <= sample_valid_in;
      if (sample_valid_in) begin
        x_prev <= sample_in;
        y_prev <= sat_sample(dc_acc);
      end
    end
  end

  assign wr_data_p0 = y_prev;
`else
  localparam int dc_shift_unused = DC_SHIFT;
  assign wr_vld_p0  = sample_valid_in;
  assign wr_data_p0 = sample_in;
`endif

  logic [PW-1:0] wr_ptr;
  logic [FW-1:0] fill;
  logic [HW-1:0] hop_cnt;
  logic          hop_done;
  logic          trig;

  always_comb begin
    hop_done = (hop_cnt == HW'(HOP_LEN - 1));
    trig     = wr_vld_p0 && ((fill == FW'(FRAME_LEN - 1)) ||
                             ((fill == FW'(FRAME_LEN)) && hop_done));
  end

  // Hop grid restarts on the write that first fills the buffer, so the first frame lands there.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr  <= '0;
      fill    <= '0;
      hop_cnt <= '0;
    end else if (wr_vld_p0) begin
      wr_ptr  <= wr_ptr + PW'(1);
      if (fill != FW'(FRAME_LEN)) fill <= fill + FW'(1);
      hop_cnt <= (trig || hop_done) ? '0 : hop_cnt + HW'(1);
    end
  end

  state_t                         state;
  logic [PW-1:0]                  base;
  logic [IW-1:0]                  iss_idx;
  logic                           iss_done;
  logic                           rd_vld_p1;
  logic [IW-1:0]                  rd_idx_p1;
  logic                           rd_last_p1;
  logic signed [SAMPLE_WIDTH-1:0] rd_data_p1;
  logic                           sk_vld;
  logic [IW-1:0]                  sk_idx;
  logic                           sk_last;
  logic signed [SAMPLE_WIDTH-1:0] sk_data;

  logic          pop;
  logic          last_pop;
  logic [1:0]    occ;
  logic          issue;
  logic          sk_load;
  logic [PW-1:0] rd_addr;

  // A read may issue only if its data will find a free slot in output+skid even under a stall.
  always_comb begin
    pop      = frame_valid_out && frame_ready_in;
    last_pop = pop && frame_last_out;
    occ      = 2'(frame_valid_out) + 2'(sk_vld) + 2'(rd_vld_p1) - 2'(pop);
    issue    = (state == STREAM) && !iss_done && (occ <= 2'd1);
    sk_load  = rd_vld_p1 && frame_valid_out && (!pop || sk_vld);
    rd_addr  = base + PW'(iss_idx);
  end

  // ---- stage p1: buffer read, then output/skid registers ----
  always_ff @(posedge clk_in) begin
    if (wr_vld_p0) mem[wr_ptr] <= wr_data_p0;
    if (issue)     rd_data_p1  <= mem[rd_addr];
    if (sk_load)   sk_data     <= rd_data_p1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= IDLE;
      base            <= '0;
      iss_idx         <= '0;
      iss_done        <= 1'b0;
      rd_vld_p1       <= 1'b0;
      rd_idx_p1       <= '0;
      rd_last_p1      <= 1'b0;
      sk_vld          <= 1'b0;
      sk_idx          <= '0;
      sk_last         <= 1'b0;
      frame_valid_out <= 1'b0;
      frame_data_out  <= '0;
      frame_index_out <= '0;
      frame_last_out  <= 1'b0;
      overrun_out     <= 1'b0;
    end else begin
      rd_vld_p1 <= issue;
      if (issue) begin
        rd_idx_p1  <= iss_idx;
        rd_last_p1 <= (iss_idx == IW'(FRAME_LEN - 1));
        iss_idx    <= iss_idx + IW'(1);
        if (iss_idx == IW'(FRAME_LEN - 1)) iss_done <= 1'b1;
      end

      // A trigger coinciding with the final beat's transfer starts the next frame cleanly.
      if (trig && (state == IDLE || last_pop)) begin
        state    <= STREAM;
        base     <= wr_ptr - PW'(FRAME_LEN - 1);
        iss_idx  <= '0;
        iss_done <= 1'b0;
      end else if (trig) begin
        overrun_out <= 1'b1;
      end else if (last_pop) begin
        state <= IDLE;
      end

      if (pop && sk_vld) begin
        frame_valid_out <= 1'b1;
        frame_data_out  <= sk_data;
        frame_index_out <= sk_idx;
        frame_last_out  <= sk_last;
      end else if ((pop || !frame_valid_out) && rd_vld_p1) begin
        frame_valid_out <= 1'b1;
        frame_data_out  <= rd_data_p1;
        frame_index_out <= rd_idx_p1;
        frame_last_out  <= rd_last_p1;
      end else if (pop) begin
        frame_valid_out <= 1'b0;
      end

      if (sk_load) begin
        sk_vld  <= 1'b1;
        sk_idx  <= rd_idx_p1;
        sk_last <= rd_last_p1;
      end else if (pop && sk_vld) begin
        sk_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_audio_framer.sv
// Directed bench for audio_framer: default 512/256 instance plus an 8/4 instance for overrun.
module tb_audio_framer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    longint data;
    int     idx;
    bit     last;
  } beat_t;

  // Instance A: default geometry
  logic               rst_a = 1'b0;
  logic               a_svld = 1'b0;
  logic signed [23:0] a_sdat = '0;
  logic               a_valid;
  logic               a_ready = 1'b1;
  logic signed [23:0] a_data;
  logic [8:0]         a_idx;
  logic               a_last;
  logic               a_ovr;

  // Instance B: FRAME_LEN=8, HOP_LEN=4
  logic               rst_b = 1'b0;
  logic               b_svld = 1'b0;
  logic signed [23:0] b_sdat = '0;
  logic               b_valid;
  logic               b_ready = 1'b1;
  logic signed [23:0] b_data;
  logic [2:0]         b_idx;
  logic               b_last;
  logic               b_ovr;

  audio_framer u_dut_a (
    .clk_in          (clk),
    .rst_in          (rst_a),
    .sample_valid_in (a_svld),
    .sample_in       (a_sdat),
    .frame_valid_out (a_valid),
    .frame_ready_in  (a_ready),
    .frame_data_out  (a_data),
    .frame_index_out (a_idx),
    .frame_last_out  (a_last),
    .overrun_out     (a_ovr)
  );

  audio_framer #(.FRAME_LEN(8), .HOP_LEN(4)) u_dut_b (
    .clk_in          (clk),
    .rst_in          (rst_b),
    .sample_valid_in (b_svld),
    .sample_in       (b_sdat),
    .frame_valid_out (b_valid),
    .frame_ready_in  (b_ready),
    .frame_data_out  (b_data),
    .frame_index_out (b_idx),
    .frame_last_out  (b_last),
    .overrun_out     (b_ovr)
  );

`ifdef FRAMER_DC_BLOCK_EN
  localparam int LAT_MAX = 4;
`else
  localparam int LAT_MAX = 3;
`endif

  // Expected stored value per sample since last reset
  longint sa[$];
  longint sb[$];
  longint axp = 0, ayp = 0, bxp = 0, byp = 0;
  beat_t  a_q[$];
  beat_t  b_q[$];

  int a_send_cyc = 0;
  int a_rise_cyc = -1000;
  bit a_prev_vld = 1'b0;
  bit a_hold = 1'b0;
  beat_t a_held;
  int hold_err = 0, drop_err = 0, stalls = 0;
  bit a_rand = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic model_step(input longint x, inout longint xp, inout longint yp, output longint y);
`ifdef FRAMER_DC_BLOCK_EN
    longint t;
    t = x - xp + yp - (yp >>> 8);
    if (t > 64'sd8388607)  t = 64'sd8388607;
    if (t < -64'sd8388608) t = -64'sd8388608;
    xp = x;
    yp = t;
    y  = t;
`else
    xp = x;
    yp = x;
    y  = x;
`endif
  endtask

  task automatic a_send(input longint v, input int gap);
    longint y;
    @(posedge clk); #1;
    a_svld = 1'b1;
    a_sdat = v[23:0];
    a_send_cyc = cyc;
    model_step(v, axp, ayp, y);
    sa.push_back(y);
    @(posedge clk); #1;
    a_svld = 1'b0;
    if (gap > 2) begin
      repeat (gap - 2) @(posedge clk);
      #1;
    end
  endtask

  task automatic b_send(input longint v);
    longint y;
    @(posedge clk); #1;
    b_svld = 1'b1;
    b_sdat = v[23:0];
    model_step(v, bxp, byp, y);
    sb.push_back(y);
    @(posedge clk); #1;
    b_svld = 1'b0;
  endtask

  task automatic wait_a(input int n, input int budget);
    for (int i = 0; i < budget && a_q.size() < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input string tag, input int which, input int b0, input int s0, input int fl);
    int derr, ierr, lerr;
    beat_t bt;
    longint e;
    derr = 0; ierr = 0; lerr = 0;
    for (int j = 0; j < fl; j++) begin
      if (which == 0) begin bt = a_q[b0 + j]; e = sa[s0 + j]; end
      else            begin bt = b_q[b0 + j]; e = sb[s0 + j]; end
      if (bt.data != e) derr++;
      if (bt.idx != j) ierr++;
      if (bt.last != (j == fl - 1)) lerr++;
    end
    chk({tag, "_data_errs"}, derr, 0);
    chk({tag, "_index_errs"}, ierr, 0);
    chk({tag, "_last_errs"}, lerr, 0);
  endtask

  // Beat capture and stall-stability tracking for A
  initial forever begin
    @(negedge clk);
    if (!rst_a) begin
      a_hold = 1'b0;
      a_prev_vld = 1'b0;
    end else begin
      if (a_hold) begin
        if (!a_valid) drop_err++;
        else if (a_data != a_held.data || a_idx != a_held.idx || a_last != a_held.last) hold_err++;
      end
      if (a_valid && !a_ready) begin
        a_hold = 1'b1;
        a_held.data = a_data;
        a_held.idx  = int'(a_idx);
        a_held.last = a_last;
        stalls++;
      end else begin
        a_hold = 1'b0;
      end
      if (a_valid && !a_prev_vld) a_rise_cyc = cyc;
      a_prev_vld = a_valid;
      if (a_valid && a_ready) a_q.push_back('{data: longint'(a_data), idx: int'(a_idx), last: a_last});
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_b && b_valid && b_ready)
      b_q.push_back('{data: longint'(b_data), idx: int'(b_idx), last: b_last});
  end

  initial forever begin
    @(posedge clk); #1;
    if (a_rand) a_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    int mark;
    int lat;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_a_index", a_idx, 0);
    chk("rst_a_last", a_last, 0);
    chk("rst_a_overrun", a_ovr, 0);
    chk("rst_b_valid", b_valid, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Warm-up: no frame until the 512th sample
    for (int i = 1; i <= 511; i++) a_send(i, 4);
    chk("warm_no_beats", a_q.size(), 0);
    a_send(512, 4);
    mark = a_send_cyc;
    wait_a(512, 800);
    repeat (20) @(posedge clk);
    #1;
    lat = a_rise_cyc - mark;
    chk("first_latency_ok", (lat >= 0 && lat <= LAT_MAX), 1);
    chk("f1_count", a_q.size(), 512);
    chk_frame("f1", 0, 0, 0, 512);

    // Hop: second frame covers samples 257..768
    for (int i = 513; i <= 768; i++) a_send(i, 4);
    wait_a(1024, 800);
    repeat (20) @(posedge clk);
    #1;
    chk("f2_count", a_q.size(), 1024);
    chk_frame("f2", 0, 512, 256, 512);
    chk("f2_no_overrun", a_ovr, 0);

    // Backpressure on frame 3
    for (int i = 769; i <= 1023; i++) a_send(i, 4);
    a_rand = 1'b1;
    a_send(1024, 4);
    wait_a(1536, 3000);
    a_rand = 1'b0;
    a_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("f3_count", a_q.size(), 1536);
    chk_frame("f3", 0, 1024, 512, 512);
    chk("bp_hold_errs", hold_err, 0);
    chk("bp_drop_errs", drop_err, 0);
    chk("bp_stalls_seen", (stalls > 0), 1);

    // Reset in the middle of frame 4
    for (int i = 1025; i <= 1280; i++) a_send(i, 4);
    wait_a(1536 + 100, 800);
    @(posedge clk); #1;
    rst_a = 1'b0;
    #1;
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_data", a_data, 0);
    chk("mid_rst_index", a_idx, 0);
    chk("mid_rst_last", a_last, 0);
    chk("mid_rst_overrun", a_ovr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b1;
    sa.delete();
    axp = 0;
    ayp = 0;
    mark = a_q.size();
    for (int i = 0; i < 511; i++) a_send(3000 + i, 2);
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_no_early", a_q.size(), mark);
    a_send(3511, 2);
    wait_a(mark + 512, 800);
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_count", a_q.size(), mark + 512);
    chk_frame("post_rst", 0, mark, 0, 512);

    // Overrun on the small instance
    for (int k = 1; k <= 8; k++) b_send(k);
    b_ready = 1'b0;
    for (int k = 9; k <= 18; k++) begin
      b_send(k);
      if (k == 11) chk("ovr_before_drop", b_ovr, 0);
      if (k == 12) chk("ovr_at_drop", b_ovr, 1);
    end
    b_ready = 1'b1;
    for (int k = 19; k <= 24; k++) b_send(k);
    repeat (40) @(posedge clk);
    #1;
    chk("ovr_beat_count", b_q.size(), 16);
    chk_frame("ovr_inflight", 1, 0, 0, 8);
    chk_frame("ovr_next", 1, 8, 16, 8);
    chk("ovr_sticky", b_ovr, 1);

`ifdef FRAMER_DC_BLOCK_EN
    // Positive step from full-scale negative must clamp, not wrap
    @(posedge clk); #1;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    sb.delete();
    bxp = 0;
    byp = 0;
    mark = b_q.size();
    b_send(-64'sd8388608);
    for (int k = 0; k < 7; k++) b_send(64'sd8388607);
    repeat (40) @(posedge clk);
    #1;
    chk("dc_count", b_q.size(), mark + 8);
    chk("dc_neg_full", b_q[mark].data, -64'sd8388608);
    chk("dc_step_sat", b_q[mark + 1].data, 64'sd8388607);
    chk_frame("dc_frame", 1, mark, 0, 8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
